// File: rtl/systolic_pkg.sv
// +----------------------------------------------------------------------------+
// | systolic_pkg                                                               |
// | Shared result/row types and default array geometry for the systolic array. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package systolic_pkg;

   localparam int c_N_SIZE           = 32;
   localparam int c_DATAWIDTH_OUTPUT = 32;

   typedef logic [c_DATAWIDTH_OUTPUT-1:0] acc_t;
   typedef acc_t [c_N_SIZE-1:0]           row_t;

   // A pushed row closes its tile once its index reaches tile_rows-1 (a zero tile counts as one row).
   function automatic logic tile_last(input logic [15:0] row_idx, input logic [15:0] tile_rows);
      logic [15:0] last_idx;
      last_idx = (tile_rows == 16'd0) ? 16'd0 : tile_rows - 16'd1;
      return (row_idx >= last_idx);
   endfunction

endpackage

`default_nettype wire

// File: rtl/drain_fifo.sv
// +----------------------------------------------------------------------------+
// | drain_fifo                                                                 |
// | Synchronous FIFO with combinational head, count/full/empty status.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module drain_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int                c_PTR_W    = $clog2(DEPTH);
   localparam logic [c_PTR_W:0]  c_FULL_CNT = (c_PTR_W+1)'(DEPTH);

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_PTR_W:0]   r_count;
   logic               w_wr_en;
   logic               w_rd_en;

   // A write into a full FIFO is allowed when the head leaves on the same edge.
   assign w_rd_en = pop & ~empty;
   assign w_wr_en = push & (~full | w_rd_en);

   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + (c_PTR_W)'(1);
         end
         if (w_rd_en) begin
            r_rd_ptr <= r_rd_ptr + (c_PTR_W)'(1);
         end
         case ({w_wr_en, w_rd_en})
            2'b10:   r_count <= r_count + (c_PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (c_PTR_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign empty = (r_count == '0);
   assign full  = (r_count == c_FULL_CNT);
   assign count = r_count;
   // Storage is not reset, so the head reads as zero whenever nothing is held.
   assign dout  = empty ? '0 : r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/systolic_drain_collector.sv
// +----------------------------------------------------------------------------+
// | systolic_drain_collector                                                   |
// | Deskews the array's bottom-edge column results into rows and buffers them  |
// | for a valid/ready consumer. Optional DRAIN_ROWCNT_EN adds tile-last tags.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module systolic_drain_collector
   import systolic_pkg::*;
#(
   parameter int DATAWIDTH_output = c_DATAWIDTH_OUTPUT,
   parameter int N_SIZE           = c_N_SIZE,
   parameter int FIFO_DEPTH       = 4,
   parameter int AFULL_LVL        = 2
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic [N_SIZE-1:0][DATAWIDTH_output-1:0]   col_in,
   input  logic                                      col0_valid,
   input  logic [15:0]                               tile_rows,
   input  logic                                      clr_ovf,
   output logic [N_SIZE-1:0][DATAWIDTH_output-1:0]   out_row,
   output logic                                      out_valid,
   input  logic                                      out_ready,
   output logic                                      out_last,
   output logic [$clog2(FIFO_DEPTH):0]               fifo_count,
   output logic                                      almost_full,
   output logic                                      overflow
);

   localparam int                             c_ROW_W  = N_SIZE * DATAWIDTH_output;
   localparam int                             c_CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam logic [$clog2(FIFO_DEPTH):0]    c_AFULL  = (c_CNT_W)'(AFULL_LVL);

   logic [N_SIZE-1:0][DATAWIDTH_output-1:0] w_aligned_row;
   logic                                    w_aligned_vld;
   logic                                    w_full;
   logic                                    w_empty;
   logic                                    w_pop;
   logic                                    w_drop;
   logic                                    r_overflow;

   // Column k arrives k cycles late, so it is held N_SIZE-1-k cycles to line up.
   for (genvar k = 0; k < N_SIZE; k++) begin : g_col
      localparam int c_STAGES = N_SIZE - 1 - k;
      if (c_STAGES == 0) begin : g_pass
         assign w_aligned_row[k] = col_in[k];
      end else begin : g_dly
         logic [DATAWIDTH_output-1:0] r_dly [c_STAGES];
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int s = 0; s < c_STAGES; s++) begin
                  r_dly[s] <= '0;
               end
            end else begin
               r_dly[0] <= col_in[k];
               for (int s = 1; s < c_STAGES; s++) begin
                  r_dly[s] <= r_dly[s-1];
               end
            end
         end
         assign w_aligned_row[k] = r_dly[c_STAGES-1];
      end
   end

   if (N_SIZE > 1) begin : g_vld_sr
      logic r_vld [N_SIZE-1];
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int s = 0; s < N_SIZE-1; s++) begin
               r_vld[s] <= 1'b0;
            end
         end else begin
            r_vld[0] <= col0_valid;
            for (int s = 1; s < N_SIZE-1; s++) begin
               r_vld[s] <= r_vld[s-1];
            end
         end
      end
      assign w_aligned_vld = r_vld[N_SIZE-2];
   end else begin : g_vld_pass
      assign w_aligned_vld = col0_valid;
   end

   assign out_valid = ~w_empty;
   assign w_pop     = ~w_empty & out_ready;
   // The array cannot stall: a row meeting a full FIFO with no pop is lost.
   assign w_drop    = w_aligned_vld & w_full & ~w_pop;

`ifdef DRAIN_ROWCNT_EN
   logic [15:0]    r_row_cnt;
   logic           w_tag;
   logic [c_ROW_W:0] w_din;
   logic [c_ROW_W:0] w_dout;

   assign w_tag = tile_last(r_row_cnt, tile_rows);
   assign w_din = {w_tag, w_aligned_row};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_row_cnt <= '0;
      end else if (w_aligned_vld && !w_drop) begin
         r_row_cnt <= w_tag ? 16'd0 : r_row_cnt + 16'd1;
      end
   end

   drain_fifo #(
      .WIDTH (c_ROW_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_aligned_vld),
      .pop   (w_pop),
      .din   (w_din),
      .dout  (w_dout),
      .count (fifo_count),
      .full  (w_full),
      .empty (w_empty)
   );

   assign out_row  = w_dout[c_ROW_W-1:0];
   assign out_last = w_dout[c_ROW_W];
`else
   logic [c_ROW_W-1:0] w_din;
   logic [c_ROW_W-1:0] w_dout;
   logic               w_unused_tile_rows;

   assign w_din              = w_aligned_row;
   assign w_unused_tile_rows = ^tile_rows;

   drain_fifo #(
      .WIDTH (c_ROW_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_aligned_vld),
      .pop   (w_pop),
      .din   (w_din),
      .dout  (w_dout),
      .count (fifo_count),
      .full  (w_full),
      .empty (w_empty)
   );

   assign out_row  = w_dout;
   assign out_last = 1'b0;
`endif

   // A new drop outranks a clear arriving in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end else if (clr_ovf) begin
         r_overflow <= 1'b0;
      end
   end

   assign overflow    = r_overflow;
   assign almost_full = (fifo_count >= c_AFULL);

endmodule

`default_nettype wire

// File: tb/tb_systolic_drain_collector.sv
// +----------------------------------------------------------------------------+
// | tb_systolic_drain_collector                                                |
// | Drives logical rows as skewed columns and compares every cycle against a   |
// | queue model of the row FIFO. Honours DRAIN_ROWCNT_EN for out_last.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_systolic_drain_collector;

   localparam int DW    = 32;
   localparam int N     = 4;
   localparam int DEPTH = 4;
   localparam int AFULL = 2;
   localparam int MAXC  = 2048;

   logic                  clk = 1'b0;
   logic                  rst = 1'b0;
   logic [N-1:0][DW-1:0]  col_in;
   logic                  col0_valid = 1'b0;
   logic [15:0]           tile_rows  = 16'd3;
   logic                  clr_ovf    = 1'b0;
   logic [N-1:0][DW-1:0]  out_row;
   logic                  out_valid;
   logic                  out_ready  = 1'b0;
   logic                  out_last;
   logic [$clog2(DEPTH):0] fifo_count;
   logic                  almost_full;
   logic                  overflow;

   always #5 clk = ~clk;

   systolic_drain_collector #(
      .DATAWIDTH_output (DW),
      .N_SIZE           (N),
      .FIFO_DEPTH       (DEPTH),
      .AFULL_LVL        (AFULL)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .col_in      (col_in),
      .col0_valid  (col0_valid),
      .tile_rows   (tile_rows),
      .clr_ovf     (clr_ovf),
      .out_row     (out_row),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_last    (out_last),
      .fifo_count  (fifo_count),
      .almost_full (almost_full),
      .overflow    (overflow)
   );

   typedef struct {
      logic [N*DW-1:0] data;
      bit              last;
   } row_rec_t;

   row_rec_t       q[$];
   bit             start_v [MAXC];
   logic [DW-1:0]  start_d [MAXC][N];
   int             cyc      = 0;
   int             n_cmp    = 0;
   int             n_bad    = 0;
   int             m_pushed = 0;
   bit             m_ovf    = 1'b0;

   task automatic check_eq(input string tag, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, act, exp);
      end
   endtask

   task automatic check_outputs();
      check_eq("out_valid",   out_valid,   q.size() != 0);
      check_eq("out_row",     out_row,     (q.size() != 0) ? q[0].data : '0);
      check_eq("out_last",    out_last,    (q.size() != 0) ? q[0].last : 1'b0);
      check_eq("fifo_count",  fifo_count,  q.size());
      check_eq("almost_full", almost_full, q.size() >= AFULL);
      check_eq("overflow",    overflow,    m_ovf);
   endtask

   // One clock cycle: v starts a logical row now, its columns follow on later cycles.
   task automatic step(input bit v, input bit rdy, input bit clr, input bit fixed);
      bit       pop;
      bit       do_push;
      bit       ovf_set;
      int       src;
      int       eff_tile;
      row_rec_t r;
      if (cyc >= MAXC) begin
         n_bad++;
         $display("FAIL cycle_budget: got %0d cycles, expected < %0d", cyc, MAXC);
         $fatal(1, "cycle budget exhausted");
      end
      start_v[cyc] = v;
      for (int k = 0; k < N; k++) begin
         start_d[cyc][k] = fixed ? DW'(10 + k) : DW'($urandom);
      end
      for (int k = 0; k < N; k++) begin
         col_in[k] = (cyc >= k && start_v[cyc-k]) ? start_d[cyc-k][k] : DW'($urandom);
      end
      col0_valid = v;
      out_ready  = rdy;
      clr_ovf    = clr;
      #1;
      check_outputs();

      pop      = (q.size() != 0) && rdy;
      src      = cyc - (N - 1);
      do_push  = 1'b0;
      ovf_set  = 1'b0;
      eff_tile = (tile_rows == 16'd0) ? 1 : int'(tile_rows);
      r.data   = '0;
      r.last   = 1'b0;
      if (src >= 0 && start_v[src]) begin
         if (q.size() < DEPTH || pop) begin
            for (int k = 0; k < N; k++) begin
               r.data[k*DW +: DW] = start_d[src][k];
            end
`ifdef DRAIN_ROWCNT_EN
            r.last = ((m_pushed % eff_tile) == eff_tile - 1);
`endif
            m_pushed++;
            do_push = 1'b1;
         end else begin
            ovf_set = 1'b1;
         end
      end
      m_ovf = ovf_set ? 1'b1 : (clr ? 1'b0 : m_ovf);
      if (pop) begin
         void'(q.pop_front());
      end
      if (do_push) begin
         q.push_back(r);
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_out_valid"},   out_valid,   1'b0);
      check_eq({tag, "_out_row"},     out_row,     '0);
      check_eq({tag, "_out_last"},    out_last,    1'b0);
      check_eq({tag, "_fifo_count"},  fifo_count,  '0);
      check_eq({tag, "_almost_full"}, almost_full, 1'b0);
      check_eq({tag, "_overflow"},    overflow,    1'b0);
   endtask

   task automatic do_reset();
      col0_valid = 1'b0;
      out_ready  = 1'b0;
      clr_ovf    = 1'b0;
      rst        = 1'b1;
      #1;
      check_all_zero("rst_async");
      @(posedge clk);
      @(negedge clk);
      check_all_zero("rst_held");
      rst = 1'b0;
      q.delete();
      m_ovf    = 1'b0;
      m_pushed = 0;
      for (int i = 0; i <= cyc && i < MAXC; i++) begin
         start_v[i] = 1'b0;
      end
      cyc++;
   endtask

   task automatic random_run(input int cycles);
      bit lazy;
      for (int i = 0; i < cycles; i++) begin
         lazy = ((i / 40) % 2) == 1;
         step(($urandom % 2) == 1,
              lazy ? (($urandom % 4) == 0) : (($urandom % 4) != 0),
              ($urandom % 16) == 0, 1'b0);
      end
      repeat (8) step(1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      col_in = '0;
      @(negedge clk);
      do_reset();

      // Single skewed row with column values 10+k.
      step(1'b1, 1'b1, 1'b0, 1'b1);
      repeat (6) step(1'b0, 1'b1, 1'b0, 1'b0);

      // Eight back-to-back rows drained as they arrive.
      repeat (8) step(1'b1, 1'b1, 1'b0, 1'b0);
      repeat (5) step(1'b0, 1'b1, 1'b0, 1'b0);

      // Stalled consumer: four rows fill the FIFO, the fifth is dropped.
      repeat (5) step(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0);
      repeat (5) step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);

      // Full FIFO with the fifth row landing on a pop.
      for (int i = 0; i < 8; i++) begin
         step(i < 5, i == 7, 1'b0, 1'b0);
      end
      repeat (6) step(1'b0, 1'b1, 1'b0, 1'b0);

      // Reset with two rows buffered and one still in the delay line.
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      do_reset();
      repeat (8) step(1'b0, 1'b1, 1'b0, 1'b0);

      random_run(320);

      do_reset();
      tile_rows = 16'd0;
      random_run(60);

      do_reset();
      tile_rows = 16'd5;
      random_run(80);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
